// File: rtl/pipe_ex_stage_if.sv
// ---------------------------------------------------------------------------
// pipe_ex_stage_if
// Bundles the execute-stage pipeline signals: ID/EX operands in, MEM/WB
// forwarding sources in, EX/MEM register out, and the stall request.
//   master : the surrounding pipeline (drives ID/EX, MEM/WB, flush)
//   slave  : pipe_ex_stage itself
// Optional feature macro: EX_FWD_EN. When undefined, the forwarding-only
// signals (rs_in, rt_in, memwb_*) are not part of the bundle.
// ---------------------------------------------------------------------------
interface pipe_ex_stage_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_W  = 3
);

  // kill current EX instruction
  logic              flush;

  // ID/EX register outputs
  logic [3:0]        opcode_in;
  logic [DATA_W-1:0] A_in;
  logic [DATA_W-1:0] B_in;
  logic [REG_W-1:0]  rd_in;

`ifdef EX_FWD_EN
  // source indices and MEM/WB writeback, only needed for forwarding
  logic [REG_W-1:0]  rs_in;
  logic [REG_W-1:0]  rt_in;
  logic              memwb_regwrite;
  logic [REG_W-1:0]  memwb_rd;
  logic [DATA_W-1:0] memwb_data;
`endif

  // EX/MEM register
  logic [3:0]        exmem_opcode;
  logic [DATA_W-1:0] exmem_result;
  logic [DATA_W-1:0] exmem_store_data;
  logic [REG_W-1:0]  exmem_rd;
  logic              exmem_regwrite;
  logic              exmem_memread;
  logic              exmem_memwrite;

  // combinational stall request to upstream stages
  logic              ex_busy;

  modport master (
`ifdef EX_FWD_EN
    output rs_in, rt_in, memwb_regwrite, memwb_rd, memwb_data,
`endif
    output flush, opcode_in, A_in, B_in, rd_in,
    input  exmem_opcode, exmem_result, exmem_store_data, exmem_rd,
    input  exmem_regwrite, exmem_memread, exmem_memwrite, ex_busy
  );

  modport slave (
`ifdef EX_FWD_EN
    input  rs_in, rt_in, memwb_regwrite, memwb_rd, memwb_data,
`endif
    input  flush, opcode_in, A_in, B_in, rd_in,
    output exmem_opcode, exmem_result, exmem_store_data, exmem_rd,
    output exmem_regwrite, exmem_memread, exmem_memwrite, ex_busy
  );

endinterface

// File: rtl/pipe_ex_stage.sv
// ---------------------------------------------------------------------------
// pipe_ex_stage
// Execute stage of an in-order pipeline. Takes the ID/EX register contents,
// resolves operand forwarding (own EX/MEM first, then MEM/WB), runs a
// single-cycle ALU op or an iterative DATA_W-step shift-add multiply, and
// drives the EX/MEM pipeline register.
//
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset, dominates flush and everything else
//   ex   - pipe_ex_stage_if.slave:
//            flush, opcode_in, A_in, B_in, rd_in          (in)
//            rs_in, rt_in, memwb_regwrite/rd/data         (in, EX_FWD_EN only)
//            exmem_opcode/result/store_data/rd            (out, registered)
//            exmem_regwrite/memread/memwrite              (out, registered)
//            ex_busy                                      (out, combinational)
//
// Optional feature macro: EX_FWD_EN
//   defined   - EX/MEM and MEM/WB forwarding muxes on both operands
//   undefined - operands are always A_in/B_in; hazards resolved by stalls
//
// Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 MUL,
//          9 LOAD, 10 STORE, 11-15 treated as bubbles.
// ---------------------------------------------------------------------------
module pipe_ex_stage #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_W  = 3
) (
  input  logic            clk,
  input  logic            rst,
  pipe_ex_stage_if.slave  ex
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned SH_W  = 3;
  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [OP_W-1:0] OP_ADD   = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd2;
  localparam logic [OP_W-1:0] OP_AND   = 4'd3;
  localparam logic [OP_W-1:0] OP_OR    = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd5;
  localparam logic [OP_W-1:0] OP_SLL   = 4'd6;
  localparam logic [OP_W-1:0] OP_SRL   = 4'd7;
  localparam logic [OP_W-1:0] OP_MUL   = 4'd8;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'd9;
  localparam logic [OP_W-1:0] OP_STORE = 4'd10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  // EX/MEM pipeline register payload; all-zero is the canonical bubble
  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  rd;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
  } exmem_t;

  state_e            state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [DATA_W-1:0] acc_q,    acc_d;
  logic [DATA_W-1:0] mcand_q,  mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  exmem_t            exmem_q,  exmem_d;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] step_acc;
  exmem_t            alu_pkt;
  logic              busy_c;

`ifdef EX_FWD_EN
  // EX/MEM wins over MEM/WB; a LOAD in EX/MEM is never a forwarding source
  // because its data does not exist yet (the hazard unit stalls instead).
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [REG_W-1:0]  idx,
    input logic [DATA_W-1:0] raw,
    input exmem_t            exm,
    input logic              wb_we,
    input logic [REG_W-1:0]  wb_rd,
    input logic [DATA_W-1:0] wb_data
  );
    logic [DATA_W-1:0] sel;
    sel = raw;
    if (exm.regwrite && !exm.memread && (exm.rd != '0) && (exm.rd == idx)) begin
      sel = exm.result;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == idx)) begin
      sel = wb_data;
    end
    return sel;
  endfunction

  // Forwarded operands
  always_comb begin
    op_a = fwd_sel(ex.rs_in, ex.A_in, exmem_q, ex.memwb_regwrite, ex.memwb_rd, ex.memwb_data);
    op_b = fwd_sel(ex.rt_in, ex.B_in, exmem_q, ex.memwb_regwrite, ex.memwb_rd, ex.memwb_data);
  end
`else
  // Raw operands straight from ID/EX
  always_comb begin
    op_a = ex.A_in;
    op_b = ex.B_in;
  end
`endif

  // Single-cycle ALU; LOAD/STORE share the adder for address generation
  always_comb begin
    alu_res = '0;
    case (ex.opcode_in)
      OP_ADD, OP_LOAD, OP_STORE: alu_res = op_a + op_b;
      OP_SUB:                    alu_res = op_a - op_b;
      OP_AND:                    alu_res = op_a & op_b;
      OP_OR:                     alu_res = op_a | op_b;
      OP_XOR:                    alu_res = op_a ^ op_b;
      OP_SLL:                    alu_res = op_a << op_b[SH_W-1:0];
      OP_SRL:                    alu_res = op_a >> op_b[SH_W-1:0];
      default:                   alu_res = '0;
    endcase
  end

  // EX/MEM payload for a non-MUL instruction
  always_comb begin
    alu_pkt = '0;
    case (ex.opcode_in)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: begin
        alu_pkt.opcode   = ex.opcode_in;
        alu_pkt.result   = alu_res;
        alu_pkt.rd       = ex.rd_in;
        alu_pkt.regwrite = 1'b1;
      end
      OP_LOAD: begin
        alu_pkt.opcode   = ex.opcode_in;
        alu_pkt.result   = alu_res;
        alu_pkt.rd       = ex.rd_in;
        alu_pkt.regwrite = 1'b1;
        alu_pkt.memread  = 1'b1;
      end
      OP_STORE: begin
        alu_pkt.opcode     = ex.opcode_in;
        alu_pkt.result     = alu_res;
        alu_pkt.store_data = op_b;
        alu_pkt.rd         = ex.rd_in;
        alu_pkt.memwrite   = 1'b1;
      end
      default: alu_pkt = '0;
    endcase
  end

  // One shift-add step: accumulate the multiplicand when the current
  // multiplier LSB is set. Only the low DATA_W bits are kept, which is
  // exactly the truncated product.
  always_comb begin
    step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Next-state, multiply datapath and EX/MEM capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    exmem_d  = '0;
    busy_c   = 1'b0;

    if (ex.flush) begin
      // bubble into EX/MEM, any multiply in flight is dropped
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ex.opcode_in == OP_MUL) begin
            busy_c   = 1'b1;
            mcand_d  = op_a;
            mplier_d = op_b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_BUSY;
          end else begin
            exmem_d = alu_pkt;
          end
        end

        S_BUSY: begin
          acc_d    = step_acc;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_q == CNT_LAST) begin
            // last step: ID/EX is released this edge, so its rd/opcode
            // still belong to the multiply
            exmem_d.opcode   = ex.opcode_in;
            exmem_d.result   = step_acc;
            exmem_d.rd       = ex.rd_in;
            exmem_d.regwrite = 1'b1;
            cnt_d            = '0;
            state_d          = S_IDLE;
          end else begin
            busy_c = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and EX/MEM register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      exmem_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      exmem_q  <= exmem_d;
    end
  end

  assign ex.exmem_opcode     = exmem_q.opcode;
  assign ex.exmem_result     = exmem_q.result;
  assign ex.exmem_store_data = exmem_q.store_data;
  assign ex.exmem_rd         = exmem_q.rd;
  assign ex.exmem_regwrite   = exmem_q.regwrite;
  assign ex.exmem_memread    = exmem_q.memread;
  assign ex.exmem_memwrite   = exmem_q.memwrite;
  assign ex.ex_busy          = busy_c;

endmodule

// File: tb/tb_pipe_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_ex_stage
// Directed bench for pipe_ex_stage. A transaction-level model predicts the
// EX/MEM register and ex_busy every cycle; hand-computed literals pin the
// key results. Works with EX_FWD_EN defined or undefined.
// ---------------------------------------------------------------------------
module tb_pipe_ex_stage;

  localparam int unsigned DW = 8;
  localparam int unsigned RW = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_ex_stage_if #(.DATA_W(DW), .REG_W(RW)) bus ();

  pipe_ex_stage #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] res;
    logic [DW-1:0] st;
    logic [RW-1:0] rd;
    logic          rw;
    logic          mr;
    logic          mw;
    int            rem;   // multiply cycles still to go in BUSY, 0 = idle
    logic [DW-1:0] prod;
  } mstate_t;

  mstate_t m;
  logic    model_valid = 1'b0;

  int errors = 0;
  int checks = 0;

`ifdef EX_FWD_EN
  function automatic logic [DW-1:0] fwd(input mstate_t c, input logic [RW-1:0] idx,
                                        input logic [DW-1:0] raw);
    if (c.rw && !c.mr && c.rd != 0 && c.rd == idx) return c.res;
    if (bus.memwb_regwrite && bus.memwb_rd != 0 && bus.memwb_rd == idx) return bus.memwb_data;
    return raw;
  endfunction
  function automatic logic [DW-1:0] opa(input mstate_t c);
    return fwd(c, bus.rs_in, bus.A_in);
  endfunction
  function automatic logic [DW-1:0] opb(input mstate_t c);
    return fwd(c, bus.rt_in, bus.B_in);
  endfunction
`else
  function automatic logic [DW-1:0] opa(input mstate_t c);
    return (c.rem >= 0) ? bus.A_in : bus.A_in;
  endfunction
  function automatic logic [DW-1:0] opb(input mstate_t c);
    return (c.rem >= 0) ? bus.B_in : bus.B_in;
  endfunction
`endif

  function automatic mstate_t model_step(input mstate_t c);
    mstate_t n;
    logic [DW-1:0] a, b;
    int p;
    n = c;
    n.op = 0; n.res = 0; n.st = 0; n.rd = 0; n.rw = 0; n.mr = 0; n.mw = 0;
    if (rst) begin
      n.rem = 0;
      n.prod = 0;
    end else if (bus.flush) begin
      n.rem = 0;
    end else if (c.rem > 0) begin
      if (c.rem == 1) begin
        n.op  = bus.opcode_in;
        n.res = c.prod;
        n.rd  = bus.rd_in;
        n.rw  = 1'b1;
      end
      n.rem = c.rem - 1;
    end else begin
      a = opa(c);
      b = opb(c);
      case (bus.opcode_in)
        4'd8: begin
          p = int'(a) * int'(b);
          n.prod = p[DW-1:0];
          n.rem  = DW;
        end
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10: begin
          case (bus.opcode_in)
            4'd2:    n.res = a - b;
            4'd3:    n.res = a & b;
            4'd4:    n.res = a | b;
            4'd5:    n.res = a ^ b;
            4'd6:    n.res = a << (b % 8);
            4'd7:    n.res = a >> (b % 8);
            default: n.res = a + b;
          endcase
          n.op = bus.opcode_in;
          n.rd = bus.rd_in;
          n.rw = (bus.opcode_in != 4'd10);
          n.mr = (bus.opcode_in == 4'd9);
          n.mw = (bus.opcode_in == 4'd10);
          if (bus.opcode_in == 4'd10) n.st = b;
        end
        default: ;
      endcase
    end
    return n;
  endfunction

  initial begin
    m = '{op: 0, res: 0, st: 0, rd: 0, rw: 0, mr: 0, mw: 0, rem: 0, prod: 0};
  end

  always @(posedge clk) begin
    m           <= model_step(m);
    model_valid <= 1'b1;
  end

  // ---------------- literal expectations handed to the checker ----------------
  localparam int SEL_RES = 0, SEL_RW = 1, SEL_MR = 2, SEL_MW = 3,
                 SEL_ST = 4, SEL_RD = 5, SEL_OP = 6, SEL_BUSY = 7;

  string lit_name [4];
  int    lit_sel  [4];
  int    lit_want [4];
  int    lit_n    = 0;
  int    lit_seq  = 0;
  int    lit_seen = 0;

  task automatic expect_lit(input string name, input int sel, input int want);
    lit_name[lit_n] = name;
    lit_sel[lit_n]  = sel;
    lit_want[lit_n] = want;
    lit_n = lit_n + 1;
  endtask

  task automatic publish();
    lit_seq = lit_seq + 1;
  endtask

  function automatic int dut_out(input int sel);
    case (sel)
      SEL_RES: return int'(bus.exmem_result);
      SEL_RW:  return int'(bus.exmem_regwrite);
      SEL_MR:  return int'(bus.exmem_memread);
      SEL_MW:  return int'(bus.exmem_memwrite);
      SEL_ST:  return int'(bus.exmem_store_data);
      SEL_RD:  return int'(bus.exmem_rd);
      SEL_OP:  return int'(bus.exmem_opcode);
      default: return int'(bus.ex_busy);
    endcase
  endfunction

  // ---------------- single compare process ----------------
  task automatic chk(input string name, input int got, input int want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      chk("exmem_opcode",     int'(bus.exmem_opcode),     int'(m.op));
      chk("exmem_result",     int'(bus.exmem_result),     int'(m.res));
      chk("exmem_store_data", int'(bus.exmem_store_data), int'(m.st));
      chk("exmem_rd",         int'(bus.exmem_rd),         int'(m.rd));
      chk("exmem_regwrite",   int'(bus.exmem_regwrite),   int'(m.rw));
      chk("exmem_memread",    int'(bus.exmem_memread),    int'(m.mr));
      chk("exmem_memwrite",   int'(bus.exmem_memwrite),   int'(m.mw));
      chk("ex_busy", int'(bus.ex_busy),
          (!bus.flush && ((m.rem == 0) ? (bus.opcode_in == 4'd8) : (m.rem > 1))) ? 1 : 0);
    end
    if (lit_seq != lit_seen) begin
      for (int k = 0; k < lit_n; k++) chk(lit_name[k], dut_out(lit_sel[k]), lit_want[k]);
      lit_seen = lit_seq;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    lit_n = 0;
  endtask

  task automatic set_in(input int op, input int a, input int b,
                        input int rs, input int rt, input int rd);
    bus.opcode_in = 4'(op);
    bus.A_in      = DW'(a);
    bus.B_in      = DW'(b);
    bus.rd_in     = RW'(rd);
`ifdef EX_FWD_EN
    bus.rs_in     = RW'(rs);
    bus.rt_in     = RW'(rt);
`else
    if (rs + rt < 0) bus.rd_in = RW'(rd);
`endif
  endtask

  task automatic set_wb(input int we, input int rd, input int data);
`ifdef EX_FWD_EN
    bus.memwb_regwrite = 1'(we);
    bus.memwb_rd       = RW'(rd);
    bus.memwb_data     = DW'(data);
`else
    if (we + rd + data < 0) bus.flush = 1'b0;
`endif
  endtask

  // ALU vectors: op, A, B, hand-computed result (no forwarding: rs=rt=0)
  int alu_vec [7][4] = '{
    '{1, 200, 100, 44},    // ADD wraps
    '{2, 3,   5,   254},   // SUB wraps
    '{3, 240, 60,  48},    // AND 0xF0 & 0x3C
    '{4, 240, 15,  255},   // OR
    '{5, 255, 15,  240},   // XOR
    '{6, 129, 9,   2},     // SLL 0x81 by 9 -> by 1
    '{7, 128, 3,   16}     // SRL 0x80 by 3
  };

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    set_in(1, 5, 3, 0, 0, 1);
    set_wb(0, 0, 0);

    // reset holds EX/MEM at zero even with an ADD presented
    tick(); tick();
    expect_lit("rst_result", SEL_RES, 0);
    expect_lit("rst_regwrite", SEL_RW, 0);
    expect_lit("rst_busy", SEL_BUSY, 0);
    publish();
    rst = 1'b0;
    tick();
    expect_lit("first_add_result", SEL_RES, 8);
    expect_lit("first_add_regwrite", SEL_RW, 1);
    publish();

    // ALU table
    for (int i = 0; i < 7; i++) begin
      set_in(alu_vec[i][0], alu_vec[i][1], alu_vec[i][2], 0, 0, i + 1);
      tick();
      expect_lit("alu_result", SEL_RES, alu_vec[i][3]);
      expect_lit("alu_rd", SEL_RD, i + 1);
      publish();
    end

    // forwarding priority: EX/MEM over MEM/WB
    set_in(1, 10, 20, 0, 0, 1);
    tick();
    set_in(2, 0, 5, 1, 0, 2);
    set_wb(1, 1, 99);
    tick();
`ifdef EX_FWD_EN
    expect_lit("fwd_exmem_wins", SEL_RES, 25);
`else
    expect_lit("nofwd_sub_raw", SEL_RES, 251);
`endif
    publish();
    set_wb(0, 0, 0);
    set_in(1, 10, 20, 0, 0, 0);
    tick();
    set_in(2, 0, 5, 1, 0, 2);
    set_wb(1, 1, 99);
    tick();
`ifdef EX_FWD_EN
    expect_lit("fwd_memwb", SEL_RES, 94);
`else
    expect_lit("nofwd_sub_raw2", SEL_RES, 251);
`endif
    publish();
    set_wb(0, 0, 0);

    // multiply 13*11: busy for 8 cycles, bubbles meanwhile, product on 9th edge
    set_in(8, 13, 11, 6, 7, 5);
    for (int i = 0; i < 8; i++) begin
      expect_lit("mul_busy", SEL_BUSY, 1);
      publish();
      tick();
      expect_lit("mul_bubble_rw", SEL_RW, 0);
    end
    expect_lit("mul_busy_last", SEL_BUSY, 0);
    publish();
    tick();
    expect_lit("mul_product", SEL_RES, 143);
    expect_lit("mul_opcode", SEL_OP, 8);
    expect_lit("mul_rd", SEL_RD, 5);
    expect_lit("mul_regwrite", SEL_RW, 1);
    publish();

    // back-to-back MUL 20*20 truncates to 144
    set_in(8, 20, 20, 6, 7, 6);
    repeat (9) tick();
    expect_lit("mul_trunc", SEL_RES, 144);
    expect_lit("mul2_rd", SEL_RD, 6);
    publish();

    // flush at BUSY count 3: no product, ever
    set_in(8, 7, 9, 3, 4, 7);
    repeat (4) tick();
    bus.flush = 1'b1;
    expect_lit("flush_busy", SEL_BUSY, 0);
    publish();
    tick();
    expect_lit("flush_bubble_rw", SEL_RW, 0);
    expect_lit("flush_bubble_op", SEL_OP, 0);
    publish();
    bus.flush = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (10) tick();
    expect_lit("flush_no_product", SEL_RES, 0);
    publish();

    // same with reset mid-multiply
    set_in(8, 7, 9, 3, 4, 7);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    expect_lit("rst_mul_result", SEL_RES, 0);
    expect_lit("rst_mul_rw", SEL_RW, 0);
    expect_lit("rst_mul_rd", SEL_RD, 0);
    publish();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (10) tick();
    expect_lit("rst_no_product", SEL_RES, 0);
    publish();

    // LOAD, then dependent SUB: load data is never forwarded from EX/MEM
    set_in(9, 4, 6, 0, 0, 3);
    tick();
    expect_lit("load_addr", SEL_RES, 10);
    expect_lit("load_memread", SEL_MR, 1);
    expect_lit("load_regwrite", SEL_RW, 1);
    publish();
    set_in(2, 50, 8, 3, 0, 4);
    tick();
    expect_lit("sub_after_load", SEL_RES, 42);
    publish();

    // STORE: address, store data, no regwrite
    set_in(10, 1, 2, 5, 6, 1);
    tick();
    expect_lit("store_addr", SEL_RES, 3);
    expect_lit("store_data", SEL_ST, 2);
    expect_lit("store_memwrite", SEL_MW, 1);
    expect_lit("store_regwrite", SEL_RW, 0);
    publish();

    // reserved opcode behaves as a bubble
    set_in(12, 9, 9, 0, 0, 2);
    tick();
    expect_lit("rsvd_regwrite", SEL_RW, 0);
    expect_lit("rsvd_result", SEL_RES, 0);
    publish();

    set_in(0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
